serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract sequencer built around one shared one-bit full-adder cell, `full_adder_using_mux`, instantiated once inside this block. It accepts two WIDTH-bit operands over a valid/ready handshake and steps the cell LSB-first, one bit per clock, holding the carry in a flop. It presents the result, carry-out and signed overflow over a second valid/ready handshake. Used where area matters more than latency, in place of a WIDTH-bit ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and mode presented.
in_ready  output  1  block can accept operands (high only in IDLE).
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
sub  input  1  0 = A+B, 1 = A-B (two's complement).
out_valid  output  1  result/cout/ovf valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  sum or difference, modulo 2^WIDTH.
cout  output  1  final carry-out; when sub=1, 1 = no borrow.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous, active-high.
  - While rst is high: state=IDLE; shift registers, carry, bit counter, result, cout and ovf all cleared to 0; out_valid=0; in_ready=1.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE), decoded combinationally from state.
  - out_valid = (state==DONE).
- IDLE:
  - On a clock edge with in_valid=1, load shA=op_a, shB = sub ? ~op_b : op_b, carry=sub, cnt=0, then go to RUN.
  - Otherwise stay in IDLE.
  - result/cout/ovf keep their last values.
- RUN (one bit per cycle):
  - Cell inputs: a=shA[0], b=shB[0], c=carry.
  - Each edge:
    - result shifts right with the cell sum entering at bit WIDTH-1.
    - shA and shB shift right.
    - carry is loaded with the cell carry.
    - cnt is incremented.
  - At the edge where cnt==WIDTH-1 (the MSB step):
    - additionally latch cout = cell carry and ovf = carry ^ cell carry (carry into MSB XOR carry out of MSB);
    - go to DONE.
  - in_valid, op_a, op_b and sub are ignored in RUN; operands are sampled only at acceptance.
- DONE:
  - out_valid=1; result, cout and ovf are stable and held.
  - On an edge with out_ready=1, go to IDLE.
  - Otherwise hold indefinitely (backpressure).
  - in_ready=0, so operands cannot overlap a pending result.
- Latency and throughput:
  - Acceptance at edge k gives out_valid=1 after edge k+WIDTH.
  - Minimum spacing between acceptances is WIDTH+2 cycles (RUN, one DONE cycle, one IDLE cycle).
- Arithmetic:
  - result = (A + B + 0) or (A + ~B + 1), truncated to WIDTH bits.
  - cout is bit WIDTH of that sum.
  - ovf is set when the operand signs make a signed overflow possible and the result sign differs from the expected sign.
- Boundary conditions:
  - Assertion of rst in RUN or DONE aborts the operation immediately: a partial result is never presented, and no out_valid pulse occurs.
  - in_valid and out_ready may both be high in DONE: only the out handshake completes, and the new operands are accepted on the following IDLE cycle.
  - out_ready while not in DONE has no effect.
  - cnt is wide enough for WIDTH-1 ($clog2(WIDTH) bits) and does not wrap mid-operation.

Test Plan:
1. WIDTH=8, add 8'h35 + 8'h4A, out_ready=1 → result=8'h7F, cout=0, ovf=0; out_valid rises exactly 8 cycles after the accepting edge; in_ready=0 throughout.
2. Add 8'hFF + 8'h01 → result=8'h00, cout=1, ovf=0. Then add 8'h7F + 8'h01 → result=8'h80, cout=0, ovf=1.
3. Subtract 8'h05 − 8'h07 → result=8'hFE, cout=0, ovf=0. Then subtract 8'h80 − 8'h01 → result=8'h7F, cout=1, ovf=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid rises, with in_valid pulsed (op_a=8'hAA) during that time → out_valid and result held, in_ready=0, pulse ignored. Raise out_ready → IDLE next cycle, in_ready=1, previous result still readable.
5. Reset mid-RUN: assert rst 3 cycles after accepting 8'h12 + 8'h34 → in_ready=1, out_valid=0, result=0, cout=0, ovf=0 during reset, and no out_valid follows. Then 8'h12 + 8'h34 → result=8'h46.
6. Back-to-back: hold in_valid=1 with out_ready=1 for 3 operations (8'h01+8'h01, 8'h10+8'h20, 8'hF0−8'h0F) → results 8'h02, 8'h30, 8'hE1 in order; acceptances spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one mux-based full-adder cell is stepped
// LSB-first, one bit per clock, with valid/ready handshakes on both sides.

module full_adder_using_mux (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic p;

  assign p     = a ^ b;
  // Propagate selects between inverting/passing c for sum and c/generate for carry.
  assign sum   = p ? ~c : c;
  assign carry = p ? c : a;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_sum;
  logic             cell_carry;
  logic             last_bit;

  full_adder_using_mux u_cell (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .c     (carry),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the datapath registers are reset too, so an aborted
  // operation never leaves a partial result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            sh_a  <= op_a;
            sh_b  <= sub ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= {cell_sum, result[WIDTH-1:1]};
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          carry  <= cell_carry;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            cout  <= cell_carry;
            ovf   <= carry ^ cell_carry;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): a reference model pushes
// expected results at acceptance; a monitor pops and compares at each output handshake.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  exp_t         sb[$];
  logic [W-1:0] seen_q[$];
  exp_t         got;
  exp_t         want;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] full;
    exp_t       e;
    full = {1'b0, a} + {1'b0, (s ? ~b : b)} + {{W{1'b0}}, s};
    e.r  = full[W-1:0];
    e.c  = full[W];
    if (!s) e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    else    e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard monitor: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(model(op_a, op_b, sub));
      if (out_valid && out_ready) begin
        checks++;
        got = '{r: result, c: cout, v: ovf};
        seen_q.push_back(result);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got r=%h c=%b v=%b, expected no output", result, cout, ovf);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL scoreboard_result: got r=%h c=%b v=%b, expected r=%h c=%b v=%b",
                     got.r, got.c, got.v, want.r, want.c, want.v);
          end
        end
      end
    end
  end

  // Present operands, wait (bounded) for acceptance, then drop in_valid.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1 within 40 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: out_valid=%b, expected 1 within 40 cycles", out_valid);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    bit ok;
    accept_op(a, b, s);
    wait_out_valid(ok);
    if (ok) begin
      checks++;
      if ({result, cout, ovf} !== {er, ec, ev}) begin
        errors++;
        $display("FAIL op_%h_%s_%h: got r=%h c=%b v=%b, expected r=%h c=%b v=%b",
                 a, s ? "sub" : "add", b, result, cout, ovf, er, ec, ev);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b r=%h c=%b v=%b, expected 1 0 00 0 0",
               in_ready, out_valid, result, cout, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    accept_op(8'h35, 8'h4A, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (i == 9) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL latency_cycle_%0d: got out_valid=%b in_ready=%b, expected %b 0",
                 i, out_valid, in_ready, (i == 9));
      end
    end
    checks++;
    if ({result, cout, ovf} !== {8'h7F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_35_4a: got r=%h c=%b v=%b, expected r=7f c=0 v=0", result, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_boundaries();
    out_ready = 1'b1;
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_subtract();
    out_ready = 1'b1;
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    accept_op(8'h11, 8'h22, 1'b0);
    wait_out_valid(ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 8'h33}) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: got out_valid=%b in_ready=%b r=%h, expected 1 0 33",
                 i, out_valid, in_ready, result);
      end
      @(posedge clk); #1;
      in_valid = (i == 1);
      op_a = 8'hAA;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 8'h33}) begin
      errors++;
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b r=%h, expected 1 0 33",
               in_ready, out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit spurious = 1'b0;
    out_ready = 1'b1;
    accept_op(8'h12, 8'h34, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run: got in_ready=%b out_valid=%b r=%h c=%b v=%b, expected 1 0 00 0 0",
               in_ready, out_valid, result, cout, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    checks++;
    if (spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_output: got out_valid pulse=%b, expected 0", spurious);
    end
    @(posedge clk); #1;
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a_t[3]   = '{8'h01, 8'h10, 8'hF0};
    logic [W-1:0] b_t[3]   = '{8'h01, 8'h20, 8'h0F};
    logic         s_t[3]   = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_r[3] = '{8'h02, 8'h30, 8'hE1};
    int           acc[3];
    int           n;
    seen_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_a = a_t[i]; op_b = b_t[i]; sub = s_t[i];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      acc[i] = cyc;
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL b2b_accept_timeout_%0d: in_ready=%b, expected 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (seen_q.size() < 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 10) begin
        errors++;
        $display("FAIL b2b_spacing_%0d: got %0d cycles, expected 10", i, acc[i] - acc[i-1]);
      end
    end
    checks++;
    if (seen_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, expected 3", seen_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen_q[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL b2b_result_%0d: got %h, expected %h", i, seen_q[i], exp_r[i]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_add_boundaries();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
